// File: rtl/route_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// route_arbiter_pkg
// Shared definitions for the router's crossbar control stage. It holds:
//   - the flit field positions and flit type codes
//   - the input/output index numbering (x=0, y=1, local=2)
//   - the crossbar select codes and the per-output lock FSM states
//   - small decode helpers (flit type, head test, XY route,
//     index/select/one-hot conversion)
// -----------------------------------------------------------------------------
package route_arbiter_pkg;

  localparam int FLIT_W  = 40;
  localparam int TYPE_HI = 39;
  localparam int TYPE_LO = 38;
  localparam int DX_HI   = 37;
  localparam int DX_LO   = 34;
  localparam int DY_HI   = 33;
  localparam int DY_LO   = 30;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  // Port numbering shared by inputs and outputs.
  localparam logic [1:0] IDX_X     = 2'd0;
  localparam logic [1:0] IDX_Y     = 2'd1;
  localparam logic [1:0] IDX_LOCAL = 2'd2;

  // Crossbar select codes.
  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_X     = 2'b01;
  localparam logic [1:0] SEL_Y     = 2'b10;
  localparam logic [1:0] SEL_LOCAL = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[TYPE_HI:TYPE_LO]);
  endfunction

  // Head and single flits both carry a destination and open a route.
  function automatic logic is_head_type(input logic [FLIT_W-1:0] flit);
    return flit[TYPE_HI];
  endfunction

  // Dimension-ordered routing: resolve x first, then y, then deliver locally.
  function automatic logic [1:0] xy_route(input logic [FLIT_W-1:0] flit,
                                          input logic [3:0] my_x,
                                          input logic [3:0] my_y);
    logic [1:0] out;
    if (flit[DX_HI:DX_LO] != my_x) begin
      out = IDX_X;
    end else if (flit[DY_HI:DY_LO] != my_y) begin
      out = IDX_Y;
    end else begin
      out = IDX_LOCAL;
    end
    return out;
  endfunction

  // Input index 0/1/2 maps onto select code 01/10/11.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      IDX_X:     sel = SEL_X;
      IDX_Y:     sel = SEL_Y;
      IDX_LOCAL: sel = SEL_LOCAL;
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = IDX_X;
      3'b010:  idx = IDX_Y;
      3'b100:  idx = IDX_LOCAL;
      default: idx = IDX_X;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      IDX_X:     oh = 3'b001;
      IDX_Y:     oh = 3'b010;
      IDX_LOCAL: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/route_arbiter_if.sv
// -----------------------------------------------------------------------------
// route_arbiter_if
// Bundles the FIFO-side and crossbar-side signals of the route arbiter.
//   din_*      head flit of the x/y/local input FIFO
//   empty_*    FIFO empty (din_* is don't-care while set)
//   ready_*    downstream of output x/y/local accepts a flit this cycle
//   control_*  crossbar select per output (00 none, 01 x, 10 y, 11 local)
//   pop_*      dequeue strobe per input FIFO
// Modports: master = environment (FIFOs, downstream), slave = route_arbiter.
// -----------------------------------------------------------------------------
interface route_arbiter_if;

  logic [route_arbiter_pkg::FLIT_W-1:0] din_x;
  logic [route_arbiter_pkg::FLIT_W-1:0] din_y;
  logic [route_arbiter_pkg::FLIT_W-1:0] din_local;
  logic       empty_x;
  logic       empty_y;
  logic       empty_local;
  logic       ready_x;
  logic       ready_y;
  logic       ready_local;
  logic [1:0] control_x;
  logic [1:0] control_y;
  logic [1:0] control_local;
  logic       pop_x;
  logic       pop_y;
  logic       pop_local;

  modport master (
    output din_x, din_y, din_local,
    output empty_x, empty_y, empty_local,
    output ready_x, ready_y, ready_local,
    input  control_x, control_y, control_local,
    input  pop_x, pop_y, pop_local
  );

  modport slave (
    input  din_x, din_y, din_local,
    input  empty_x, empty_y, empty_local,
    input  ready_x, ready_y, ready_local,
    output control_x, control_y, control_local,
    output pop_x, pop_y, pop_local
  );

endinterface

// File: rtl/route_arbiter_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Three-way round-robin arbiter. Grants the first requester after the last
// granted one (order x, y, local, wrapping). The pointer only moves on a grant.
//   clk    clock
//   rst_n  synchronous active-high reset; pointer returns to local so x wins first
//   req    request vector, bit 0 = x, bit 1 = y, bit 2 = local
//   en     arbitration enable; no grant while low
//   grant  one-hot grant, combinational from req/en and the pointer
// -----------------------------------------------------------------------------
module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] grant
);

  logic [2:0] ptr_r;

  // First set request among indices a, b, c in that order.
  function automatic logic [2:0] first_req(input logic [2:0] r,
                                           input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic [1:0] c);
    logic [2:0] g;
    g = 3'b000;
    if (r[a]) begin
      g[a] = 1'b1;
    end else if (r[b]) begin
      g[b] = 1'b1;
    end else if (r[c]) begin
      g[c] = 1'b1;
    end else begin
      g = 3'b000;
    end
    return g;
  endfunction

  // Grant selection: search starts just after the last granted input.
  always_comb begin
    grant = 3'b000;
    if (en) begin
      case (ptr_r)
        3'b001:  grant = first_req(req, 2'd1, 2'd2, 2'd0);
        3'b010:  grant = first_req(req, 2'd2, 2'd0, 2'd1);
        3'b100:  grant = first_req(req, 2'd0, 2'd1, 2'd2);
        default: grant = first_req(req, 2'd0, 2'd1, 2'd2);
      endcase
    end else begin
      grant = 3'b000;
    end
  end

  // Pointer register: remembers the last granted input.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr_r <= 3'b100;
    end else if (|grant) begin
      ptr_r <= grant;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/route_arbiter.sv
// -----------------------------------------------------------------------------
// route_arbiter
// Control stage in front of the router's 3x3 crossbar. Computes the XY route
// of each input's head flit, runs round-robin wormhole arbitration per output
// and drives the crossbar selects and FIFO pops in the same cycle.
//   clk    clock, all state on the rising edge
//   rst_n  synchronous active-high reset (name kept for the codebase)
//   bus    route_arbiter_if.slave: din_*/empty_*/ready_* in,
//          control_*/pop_* out
// Parameters MY_X / MY_Y: this router's 4-bit mesh coordinates.
// -----------------------------------------------------------------------------
module route_arbiter
  import route_arbiter_pkg::*;
#(
  parameter logic [3:0] MY_X = 4'd1,
  parameter logic [3:0] MY_Y = 4'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  route_arbiter_if.slave bus
);

  logic [FLIT_W-1:0] din_s   [3];
  logic [1:0]        route_s [3];
  logic [2:0]        grant_s [3];  // per output, one-hot over inputs
  logic [1:0]        ctl_s   [3];
  logic [2:0]        empty_s;
  logic [2:0]        ready_s;
  logic [2:0]        pop_s;

  assign din_s[0] = bus.din_x;
  assign din_s[1] = bus.din_y;
  assign din_s[2] = bus.din_local;
  assign empty_s  = {bus.empty_local, bus.empty_y, bus.empty_x};
  assign ready_s  = {bus.ready_local, bus.ready_y, bus.ready_x};

  for (genvar i = 0; i < 3; i++) begin : g_route
    assign route_s[i] = xy_route(din_s[i], MY_X, MY_Y);
  end

  for (genvar o = 0; o < 3; o++) begin : g_out
    lock_state_e state_r;
    logic [1:0]  owner_r;
    logic [2:0]  req_s;
    logic [2:0]  arb_grant_s;
    logic [2:0]  lock_grant_s;
    logic [1:0]  gidx_s;
    logic        arb_en_s;
    logic        lock_fire_s;

    // Requesters: non-empty inputs whose head/single flit routes to this output.
    always_comb begin
      req_s = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (!empty_s[i] && is_head_type(din_s[i]) && (route_s[i] == 2'(o))) begin
          req_s[i] = 1'b1;
        end else begin
          req_s[i] = 1'b0;
        end
      end
    end

    // New packets are only arbitrated while the output is free and ready.
    assign arb_en_s = !rst_n && ready_s[o] && (state_r == ST_IDLE);

    rr_arbiter3 u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_s),
      .en    (arb_en_s),
      .grant (arb_grant_s)
    );

    assign gidx_s = onehot_to_idx(arb_grant_s);

    // Locked path: the owning input forwards whenever it has a flit and the output is ready.
    always_comb begin
      lock_fire_s  = 1'b0;
      lock_grant_s = 3'b000;
      if (!rst_n && (state_r == ST_LOCKED) && ready_s[o] && !empty_s[owner_r]) begin
        lock_fire_s  = 1'b1;
        lock_grant_s = idx_to_onehot(owner_r);
      end else begin
        lock_fire_s  = 1'b0;
        lock_grant_s = 3'b000;
      end
    end

    assign grant_s[o] = arb_grant_s | lock_grant_s;

    // Crossbar select for this output.
    always_comb begin
      ctl_s[o] = SEL_NONE;
      if (lock_fire_s) begin
        ctl_s[o] = idx_to_sel(owner_r);
      end else if (|arb_grant_s) begin
        ctl_s[o] = idx_to_sel(gidx_s);
      end else begin
        ctl_s[o] = SEL_NONE;
      end
    end

    // Wormhole lock FSM: a head holds the output until that input's tail passes.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        state_r <= ST_IDLE;
        owner_r <= 2'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if ((|arb_grant_s) && (flit_type(din_s[gidx_s]) == FT_HEAD)) begin
              state_r <= ST_LOCKED;
              owner_r <= gidx_s;
            end else begin
              state_r <= ST_IDLE;
              owner_r <= owner_r;
            end
          end
          ST_LOCKED: begin
            if (lock_fire_s && (flit_type(din_s[owner_r]) == FT_TAIL)) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_LOCKED;
            end
            owner_r <= owner_r;
          end
          default: begin
            state_r <= ST_IDLE;
            owner_r <= 2'd0;
          end
        endcase
      end
    end
  end

  // Each input pops if any output granted it; a flit leaves at most once per cycle.
  always_comb begin
    pop_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      pop_s[i] = grant_s[0][i] | grant_s[1][i] | grant_s[2][i];
    end
  end

  assign bus.control_x     = ctl_s[0];
  assign bus.control_y     = ctl_s[1];
  assign bus.control_local = ctl_s[2];
  assign bus.pop_x         = pop_s[0];
  assign bus.pop_y         = pop_s[1];
  assign bus.pop_local     = pop_s[2];

endmodule

// File: tb/tb_route_arbiter.sv
// -----------------------------------------------------------------------------
// tb_route_arbiter
// Directed scenarios followed by random traffic. A packet-level reference
// model (per-output lock flag, owner and last-winner) predicts every select
// and pop; directed steps also check hand-derived constants.
// -----------------------------------------------------------------------------
module tb_route_arbiter;

  localparam logic [3:0] MY_X = 4'd1;
  localparam logic [3:0] MY_Y = 4'd1;

  logic clk;
  logic rst_n;

  route_arbiter_if bus ();

  route_arbiter #(.MY_X(MY_X), .MY_Y(MY_Y)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus arrays: index 0 = x, 1 = y, 2 = local.
  logic [39:0] d [3];
  bit          e [3];
  bit          r [3];

  // Reference model state.
  bit lk   [3];
  int own  [3];
  int last [3];
  bit nlk  [3];
  int nown [3];
  int nlast[3];
  int exp_ctl [3];
  bit exp_pop [3];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy);
    logic [39:0] f;
    f = {$urandom, $urandom};
    f[39:38] = t;
    f[37:34] = dx;
    f[33:30] = dy;
    return f;
  endfunction

  function automatic int dest_out(input logic [39:0] f);
    if (f[37:34] != MY_X) return 0;
    if (f[33:30] != MY_Y) return 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s got=%b exp=%b", tag, got, want);
  endtask

  task automatic set_in(input int i, input bit emp, input logic [39:0] f);
    e[i] = emp;
    d[i] = f;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) begin
      e[i] = 1'b1;
      d[i] = 40'h0;
      r[i] = 1'b0;
    end
  endtask

  // Predict this cycle's outputs and the state after the next edge.
  task automatic model_eval();
    for (int k = 0; k < 3; k++) begin
      exp_ctl[k] = 0;
      exp_pop[k] = 1'b0;
      nlk[k]     = lk[k];
      nown[k]    = own[k];
      nlast[k]   = last[k];
    end
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        nlk[k] = 1'b0; nown[k] = 0; nlast[k] = 2;
      end
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (r[o] && lk[o]) begin
          if (!e[own[o]]) begin
            exp_ctl[o] = own[o] + 1;
            exp_pop[own[o]] = 1'b1;
            if (d[own[o]][39:38] == 2'b01) nlk[o] = 1'b0;
          end
        end else if (r[o]) begin
          bit found;
          found = 1'b0;
          for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last[o] + k) % 3;
            if (!found && !e[i] && d[i][39] && dest_out(d[i]) == o) begin
              found = 1'b1;
              exp_ctl[o] = i + 1;
              exp_pop[i] = 1'b1;
              nlast[o] = i;
              if (d[i][39:38] == 2'b10) begin
                nlk[o] = 1'b1;
                nown[o] = i;
              end
            end
          end
        end
      end
    end
  endtask

  // Apply inputs, let them settle, and compare against the model.
  task automatic drive_eval(input string tag);
    bus.din_x = d[0]; bus.din_y = d[1]; bus.din_local = d[2];
    bus.empty_x = e[0]; bus.empty_y = e[1]; bus.empty_local = e[2];
    bus.ready_x = r[0]; bus.ready_y = r[1]; bus.ready_local = r[2];
    #1;
    model_eval();
    chk({tag, "_ctl_x"}, bus.control_x, 2'(exp_ctl[0]));
    chk({tag, "_ctl_y"}, bus.control_y, 2'(exp_ctl[1]));
    chk({tag, "_ctl_l"}, bus.control_local, 2'(exp_ctl[2]));
    chk({tag, "_pop_x"}, {1'b0, bus.pop_x}, {1'b0, exp_pop[0]});
    chk({tag, "_pop_y"}, {1'b0, bus.pop_y}, {1'b0, exp_pop[1]});
    chk({tag, "_pop_l"}, {1'b0, bus.pop_local}, {1'b0, exp_pop[2]});
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      lk[k] = nlk[k]; own[k] = nown[k]; last[k] = nlast[k];
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      lk[k] = 1'b0; own[k] = 0; last[k] = 2;
    end
    clear_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset held 3 cycles with every FIFO non-empty and every output ready.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        set_in(i, 1'b0, mk(2'(i + 1), 4'(c), 4'(i)));
        r[i] = 1'b1;
      end
      drive_eval("t1");
      chk("t1_ctl_x_zero", bus.control_x, 2'b00);
      chk("t1_pop_l_zero", {1'b0, bus.pop_local}, 2'b00);
      tick();
    end
    rst_n = 1'b0;

    // 2: local single to (3,1) goes out x the same cycle.
    clear_all();
    set_in(2, 1'b0, mk(2'b11, 4'd3, 4'd1));
    r[0] = 1'b1;
    drive_eval("t2");
    chk("t2_ctl_x", bus.control_x, 2'b11);
    chk("t2_pop_l", {1'b0, bus.pop_local}, 2'b01);
    tick();

    // 3: x and y singles to (1,1) alternate on out local, x first.
    clear_all();
    r[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic [1:0] want;
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      set_in(0, 1'b0, mk(2'b11, 4'd1, 4'd1));
      set_in(1, 1'b0, mk(2'b11, 4'd1, 4'd1));
      drive_eval("t3");
      chk("t3_ctl_l_alt", bus.control_local, want);
      tick();
    end

    // 4: y packet head/body/tail holds out x; x's head waits until after the tail.
    clear_all();
    r[0] = 1'b1;
    set_in(1, 1'b0, mk(2'b10, 4'd2, 4'd0));
    drive_eval("t4h");
    chk("t4_head_ctl_x", bus.control_x, 2'b10);
    tick();
    set_in(0, 1'b0, mk(2'b10, 4'd3, 4'd1));
    set_in(1, 1'b0, mk(2'b00, 4'd0, 4'd0));
    drive_eval("t4b");
    chk("t4_body_ctl_x", bus.control_x, 2'b10);
    chk("t4_body_pop_x", {1'b0, bus.pop_x}, 2'b00);
    tick();
    set_in(1, 1'b0, mk(2'b01, 4'd0, 4'd0));
    drive_eval("t4t");
    chk("t4_tail_ctl_x", bus.control_x, 2'b10);
    tick();
    set_in(1, 1'b1, 40'h0);
    drive_eval("t4x");
    chk("t4_xwin_ctl_x", bus.control_x, 2'b01);
    chk("t4_xwin_pop_x", {1'b0, bus.pop_x}, 2'b01);
    tick();
    set_in(0, 1'b0, mk(2'b01, 4'd0, 4'd0));
    drive_eval("t4xt");
    tick();

    // 5: mid-packet stall on out x with y owning it.
    clear_all();
    r[0] = 1'b1;
    set_in(1, 1'b0, mk(2'b10, 4'd2, 4'd0));
    drive_eval("t5h");
    chk("t5_head_ctl_x", bus.control_x, 2'b10);
    tick();
    set_in(1, 1'b0, mk(2'b00, 4'd0, 4'd0));
    r[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_eval("t5s");
      chk("t5_stall_ctl_x", bus.control_x, 2'b00);
      chk("t5_stall_pop_y", {1'b0, bus.pop_y}, 2'b00);
      tick();
    end
    r[0] = 1'b1;
    drive_eval("t5b");
    chk("t5_resume_ctl_x", bus.control_x, 2'b10);
    chk("t5_resume_pop_y", {1'b0, bus.pop_y}, 2'b01);
    tick();
    set_in(1, 1'b0, mk(2'b01, 4'd0, 4'd0));
    drive_eval("t5t");
    chk("t5_tail_ctl_x", bus.control_x, 2'b10);
    tick();

    // 6: reset mid-packet; the orphan body at y is never granted afterwards.
    clear_all();
    r[0] = 1'b1;
    set_in(1, 1'b0, mk(2'b10, 4'd2, 4'd0));
    drive_eval("t6h");
    tick();
    rst_n = 1'b1;
    set_in(0, 1'b0, mk(2'b11, 4'd3, 4'd1));
    set_in(1, 1'b0, mk(2'b00, 4'd0, 4'd0));
    drive_eval("t6r");
    chk("t6_rst_ctl_x", bus.control_x, 2'b00);
    tick();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1'b0, mk(2'b11, 4'd3, 4'd1));
      drive_eval("t6a");
      chk("t6_after_ctl_x", bus.control_x, 2'b01);
      chk("t6_after_pop_y", {1'b0, bus.pop_y}, 2'b00);
      tick();
    end

    // Random traffic, including malformed type sequences and occasional resets.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 3; i++) begin
        set_in(i, ($urandom_range(0, 9) < 3), mk(2'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))));
        r[i] = ($urandom_range(0, 3) != 0);
      end
      rst_n = ($urandom_range(0, 39) == 0);
      drive_eval("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
